// File: rtl/pipelined_alu.sv
// Handshaked WIDTH-bit ALU with a registered result and error flag.
// SHR (variable right shift) and MUL (shift-add multiply) take several cycles.
module pipelined_alu #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             err
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]   count;
  logic               is_mul;
  logic [WIDTH-1:0]   work;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH-1:0]   b_op;
  logic               carry_in;
  logic [WIDTH:0]     sum_ext;
  logic               msb_carry_in;
  logic [SHAMT_W-1:0] shamt;

  logic [WIDTH-1:0]   single_res;
  logic               single_cout;
  logic               single_ovf;
  logic               single_err;
  logic               go_busy;
  logic [CNT_W-1:0]   busy_count;

  logic [WIDTH-1:0]   work_shift;
  logic [2*WIDTH-1:0] acc_step;
  logic               last_step;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign shamt     = b[SHAMT_W-1:0];

  // Single-cycle datapath; SUB reuses the adder as a + ~b + 1.
  always_comb begin
    b_op        = b;
    carry_in    = 1'b0;
    single_res  = '0;
    single_cout = 1'b0;
    single_ovf  = 1'b0;
    single_err  = 1'b0;
    go_busy     = 1'b0;
    busy_count  = '0;
    if (opcode == 4'b0001) carry_in = cin;
    if (opcode == 4'b0011) begin
      b_op     = ~b;
      carry_in = 1'b1;
    end
    sum_ext      = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, carry_in};
    msb_carry_in = a[WIDTH-1] ^ b_op[WIDTH-1] ^ sum_ext[WIDTH-1];
    case (opcode)
      4'b0001, 4'b0010, 4'b0011: begin
        single_res  = sum_ext[WIDTH-1:0];
        single_cout = sum_ext[WIDTH];
        single_ovf  = msb_carry_in ^ sum_ext[WIDTH];
      end
      4'b0100: single_res = a & b;
      4'b0101: single_res = ~(a | b);
      4'b0110: single_res = ~(a ^ b);
      4'b0111: single_res = ~a;
      4'b1000: begin
        single_res  = {1'b0, a[WIDTH-1:1]};
        single_cout = a[0];
      end
      4'b1001: begin
        if (shamt == '0) begin
          single_res = a;
        end else begin
          go_busy    = 1'b1;
          busy_count = CNT_W'(shamt);
        end
      end
      4'b1010: begin
        go_busy    = 1'b1;
        busy_count = CNT_W'(WIDTH);
      end
      default: single_err = 1'b1;
    endcase
  end

  // One BUSY step: work is the shift register for SHR and the multiplier for MUL.
  always_comb begin
    work_shift = work >> 1;
    acc_step   = acc + (work[0] ? mcand : '0);
    last_step  = (count == CNT_W'(1));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = go_busy ? BUSY : DONE;
      BUSY: if (last_step) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      err    <= 1'b0;
      count  <= '0;
      is_mul <= 1'b0;
      work   <= '0;
      mcand  <= '0;
      acc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (go_busy) begin
              count  <= busy_count;
              is_mul <= (opcode == 4'b1010);
              work   <= (opcode == 4'b1010) ? b : a;
              mcand  <= {{WIDTH{1'b0}}, a};
              acc    <= '0;
            end else begin
              result <= single_res;
              cout   <= single_cout;
              ovf    <= single_ovf;
              err    <= single_err;
              zero   <= (single_res == '0);
            end
          end
        end
        BUSY: begin
          count <= count - CNT_W'(1);
          work  <= work_shift;
          if (is_mul) begin
            mcand <= mcand << 1;
            acc   <= acc_step;
          end else begin
            cout <= work[0];
          end
          if (last_step) begin
            ovf <= 1'b0;
            err <= 1'b0;
            if (is_mul) begin
              result <= acc_step[WIDTH-1:0];
              cout   <= |acc_step[2*WIDTH-1:WIDTH];
              zero   <= (acc_step[WIDTH-1:0] == '0);
            end else begin
              result <= work_shift;
              zero   <= (work_shift == '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipelined_alu.sv
// Directed self-checking bench for pipelined_alu (WIDTH=8) with hand-computed vectors.
module tb_pipelined_alu;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] opcode;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       cout;
  logic       ovf;
  logic       zero;
  logic       err;

  int tests_run = 0;
  int tests_failed = 0;
  int cycles;
  logic ready_seen;

  pipelined_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .cout(cout), .ovf(ovf),
    .zero(zero), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Present one operation while idle; returns #1 after the accept edge.
  task automatic apply_stimulus(input logic [3:0] op, input logic [7:0] av,
                                input logic [7:0] bv, input logic cv);
    opcode   = op;
    a        = av;
    b        = bv;
    cin      = cv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid, bounded.
  task automatic wait_done(output int n, output logic rdy);
    n   = 0;
    rdy = 1'b0;
    while (!out_valid && n < 50) begin
      if (in_ready) rdy = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    opcode    = 4'h0;
    a         = 8'h00;
    b         = 8'h00;
    cin       = 1'b0;
    #12;
    check_output("reset_result", 32'(result), 32'h00);
    check_output("reset_out_valid", 32'(out_valid), 32'h0);
    check_output("reset_in_ready", 32'(in_ready), 32'h1);
    check_output("reset_flags", {28'h0, cout, ovf, zero, err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    apply_stimulus(4'b0010, 8'h7F, 8'h01, 1'b0);
    check_output("add_out_valid", 32'(out_valid), 32'h1);
    check_output("add_result", 32'(result), 32'h80);
    check_output("add_flags", {28'h0, cout, ovf, zero, err}, 32'b0100);
    release_result();
    check_output("add_back_idle", 32'(in_ready), 32'h1);

    apply_stimulus(4'b0001, 8'hFF, 8'h00, 1'b1);
    check_output("addc_result", 32'(result), 32'h00);
    check_output("addc_flags", {28'h0, cout, ovf, zero, err}, 32'b1010);
    release_result();

    apply_stimulus(4'b0011, 8'h05, 8'h07, 1'b0);
    check_output("sub1_result", 32'(result), 32'hFE);
    check_output("sub1_flags", {28'h0, cout, ovf, zero, err}, 32'b0000);
    release_result();

    apply_stimulus(4'b0011, 8'h80, 8'h01, 1'b0);
    check_output("sub2_result", 32'(result), 32'h7F);
    check_output("sub2_flags", {28'h0, cout, ovf, zero, err}, 32'b1100);
    release_result();

    apply_stimulus(4'b1010, 8'h0F, 8'h11, 1'b0);
    check_output("mul1_busy_ready", 32'(in_ready), 32'h0);
    wait_done(cycles, ready_seen);
    check_output("mul1_latency", 32'(cycles), 32'd8);
    check_output("mul1_ready_seen", 32'(ready_seen), 32'h0);
    check_output("mul1_result", 32'(result), 32'hFF);
    check_output("mul1_flags", {28'h0, cout, ovf, zero, err}, 32'b0000);
    release_result();

    apply_stimulus(4'b1010, 8'h10, 8'h10, 1'b0);
    wait_done(cycles, ready_seen);
    check_output("mul2_latency", 32'(cycles), 32'd8);
    check_output("mul2_result", 32'(result), 32'h00);
    check_output("mul2_flags", {28'h0, cout, ovf, zero, err}, 32'b1010);
    release_result();

    apply_stimulus(4'b1001, 8'hB4, 8'h03, 1'b0);
    wait_done(cycles, ready_seen);
    check_output("shr_latency", 32'(cycles), 32'd3);
    check_output("shr_result", 32'(result), 32'h16);
    check_output("shr_flags", {28'h0, cout, ovf, zero, err}, 32'b1000);
    release_result();

    apply_stimulus(4'b1001, 8'h5C, 8'h08, 1'b0);
    check_output("shr0_out_valid", 32'(out_valid), 32'h1);
    check_output("shr0_result", 32'(result), 32'h5C);
    check_output("shr0_cout", 32'(cout), 32'h0);
    release_result();

    apply_stimulus(4'b0110, 8'hF0, 8'hFF, 1'b0);
    check_output("xnor_result", 32'(result), 32'hF0);
    opcode   = 4'b0010;
    a        = 8'h01;
    b        = 8'h01;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("bp_result_held", 32'(result), 32'hF0);
    check_output("bp_out_valid", 32'(out_valid), 32'h1);
    check_output("bp_in_ready", 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_output("bp_idle", 32'(in_ready), 32'h1);
    check_output("bp_result_kept", 32'(result), 32'hF0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_output("bp_next_valid", 32'(out_valid), 32'h1);
    check_output("bp_next_result", 32'(result), 32'h02);
    release_result();

    apply_stimulus(4'b1010, 8'h0F, 8'h11, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("rst_mid_result", 32'(result), 32'h00);
    check_output("rst_mid_out_valid", 32'(out_valid), 32'h0);
    check_output("rst_mid_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus(4'b0000, 8'h12, 8'h34, 1'b0);
    check_output("illegal_result", 32'(result), 32'h00);
    check_output("illegal_flags", {28'h0, cout, ovf, zero, err}, 32'b0011);
    release_result();

    apply_stimulus(4'b1111, 8'h55, 8'h55, 1'b1);
    check_output("illegal_f_err", 32'(err), 32'h1);
    release_result();

    apply_stimulus(4'b0100, 8'hAA, 8'h0F, 1'b0);
    check_output("and_result", 32'(result), 32'h0A);
    check_output("and_flags", {28'h0, cout, ovf, zero, err}, 32'b0000);
    release_result();

    apply_stimulus(4'b1000, 8'h81, 8'h00, 1'b0);
    check_output("lsr_result", 32'(result), 32'h40);
    check_output("lsr_cout", 32'(cout), 32'h1);
    release_result();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipelined_alu.md
Name: pipelined_alu

Overview:
- Parametrised, handshaked successor to the team's 4-bit combinational ALU.
- Keeps the existing opcode map for ADD/ADDC/SUB/AND/NOR/XNOR/NOT/LSR, generalised to WIDTH bits.
- Adds a registered result, valid/ready flow control, an error flag, and two multi-cycle ops: variable right shift and shift-add multiply.
- Sits between the operand sequencer and the register writeback stage.

Parameters:
- WIDTH, 8: operand/result width in bits, must be ≥2.
- SHAMT_W, $clog2(WIDTH): width of the shift-amount field taken from B.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  block can accept a new operation.
- opcode  in  4  operation select.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in, used only by opcode 0001.
- out_valid  out  1  result registers valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- cout  out  1  carry, borrow-complement, or shifted-out bit, per opcode.
- ovf  out  1  signed overflow.
- zero  out  1  result == 0.
- err  out  1  illegal opcode flag.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - result=0; cout=ovf=zero=err=0; out_valid=0.
  - Internal counter and operand registers cleared.
  - Applies immediately, including mid-BUSY or mid-DONE; the in-flight op is discarded.
- States: IDLE, BUSY, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- Accept: at a rising edge with in_valid && in_ready. opcode/a/b/cin are sampled only at that edge; later changes are ignored.
- Single-cycle ops: result and flags are loaded at the accept edge, then IDLE→DONE. out_valid is high in the cycle after accept.
  - 0001 ADDC: a+b+cin.
  - 0010 ADD: a+b.
  - 0011 SUB: a+~b+1.
  - Arithmetic flags: cout = carry out of MSB (SUB: 1 = no borrow). ovf = carry into MSB XOR carry out of MSB.
  - 0100 AND: a&b.
  - 0101 NOR: ~(a|b).
  - 0110 XNOR: ~(a^b).
  - 0111 NOT: ~a.
  - 1000 LSR: a>>1, MSB=0, cout=a[0].
  - Logic ops and LSR: ovf=0. Logic ops: cout=0.
- 1001 SHR (variable logical right shift):
  - n = b[SHAMT_W-1:0].
  - n=0: single-cycle, result=a, cout=0.
  - n>0: IDLE→BUSY with counter=n. Each BUSY edge shifts the working register right by 1 and sets cout to the bit shifted out.
  - When the counter reaches 0, go to DONE. out_valid rises at accept edge + n.
  - ovf=0.
- 1010 MUL (unsigned shift-add):
  - Runs one multiplier bit per cycle, exactly WIDTH BUSY steps. out_valid rises at accept edge + WIDTH.
  - result = low WIDTH bits of a*b.
  - cout = OR of high WIDTH product bits (truncation indicator).
  - ovf=0.
- Illegal opcodes (0000, 1011–1111): single-cycle, result=0, cout=ovf=0, err=1. All legal ops set err=0.
- zero is computed from the final result value and loaded with it.
- DONE: result and flags are held stable while out_ready=0. At an edge with out_ready=1, go DONE→IDLE; result and flags keep their last values.
- No overlap: a new accept is possible only in IDLE, i.e. the cycle after the DONE handshake. in_valid during BUSY or DONE is ignored; the upstream holds it.
- Arithmetic is performed at WIDTH+1 bits internally, with no X-propagation on any opcode.

Test Plan (WIDTH=8):
- ADD a=0x7F b=0x01 → one cycle after accept: out_valid=1, result=0x80, cout=0, ovf=1, zero=0. ADDC a=0xFF b=0x00 cin=1 → result=0x00, cout=1, zero=1.
- SUB a=0x05 b=0x07 → result=0xFE, cout=0, ovf=0. SUB a=0x80 b=0x01 → result=0x7F, cout=1, ovf=1.
- MUL a=0x0F b=0x11 → in_ready low for 8 cycles, out_valid at accept+8, result=0xFF, cout=0. MUL a=0x10 b=0x10 → result=0x00, cout=1, zero=1.
- SHR a=0xB4 b=0x03 → out_valid at accept+3, result=0x16, cout=1. SHR with b=0x08 (n=0) → result=a after one cycle.
- Backpressure: after XNOR a=0xF0 b=0xFF (result=0xF0), hold out_ready=0 for 3 cycles with in_valid=1 → result stable, in_ready=0, no new accept. out_ready=1 → IDLE, next op is accepted the following edge.
- Reset at accept+4 during MUL → outputs 0 and in_ready=1 immediately. opcode 0000 afterwards → result=0, err=1. Following AND a=0xAA b=0x0F → result=0x0A, err=0.
